// File: rtl/raspi_spi_pkg.sv
// rtl/raspi_spi_pkg.sv - shared widths, types and command opcodes for the Pi SPI command link
package raspi_spi_pkg;

    localparam int CMD_W              = 8;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    typedef logic [CMD_W-1:0] cmd_t;

    // Opcodes understood by the consumer logic in final_project
    localparam cmd_t OP_NOP        = 8'h00;
    localparam cmd_t OP_START      = 8'h01;
    localparam cmd_t OP_STOP       = 8'h02;
    localparam cmd_t OP_READ_STR   = 8'h10;
    localparam cmd_t OP_CLEAR      = 8'h20;
    localparam cmd_t OP_SOFT_RESET = 8'hFF;

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous command FIFO, one push and one pop per cycle
module cmd_fifo
    import raspi_spi_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t head,
    output logic empty,
    output logic full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/spi_raspi_cmd_rx.sv
// rtl/spi_raspi_cmd_rx.sv - oversampled SPI command receiver from the Pi with command FIFO and action latch
module spi_raspi_cmd_rx
    import raspi_spi_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic load,
    input  logic sdi,
    output cmd_t cmd_byte,
    output logic cmd_valid,
    input  logic cmd_ready,
    output cmd_t action,
    output logic action_valid,
    output logic frame_err,
    output logic overflow
);

    logic sclk_s1, sclk_s2, sclk_s3;
    logic load_s1, load_s2, load_s3;
    logic sdi_s1, sdi_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_s3 <= 1'b0;
            load_s1 <= 1'b0; load_s2 <= 1'b0; load_s3 <= 1'b0;
            sdi_s1  <= 1'b0; sdi_s2  <= 1'b0;
        end else begin
            sclk_s1 <= sclk; sclk_s2 <= sclk_s1; sclk_s3 <= sclk_s2;
            load_s1 <= load; load_s2 <= load_s1; load_s3 <= load_s2;
            sdi_s1  <= sdi;  sdi_s2  <= sdi_s1;
        end
    end

    logic sclk_rise, load_rise, load_fall;

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign load_rise = load_s2 & ~load_s3;
    assign load_fall = ~load_s2 & load_s3;

    logic [1:0] settle;
    logic       primed;
    logic       frame_on;
    logic       has_byte;
    logic [2:0] bit_cnt;
    logic [2:0] bit_cnt_nxt;
    logic [6:0] sr;
    cmd_t       cand;
    cmd_t       new_byte;
    logic       bit_en;
    logic       byte_done;
    logic       pop;
    logic       fifo_empty;
    logic       fifo_full;

    // A bit landing in the same cycle as load_fall still belongs to the closing frame
    assign bit_en      = frame_on & sclk_rise & (load_s2 | load_fall);
    assign byte_done   = bit_en & (bit_cnt == 3'd7);
    assign new_byte    = {sr, sdi_s2};
    assign bit_cnt_nxt = bit_en ? bit_cnt + 3'd1 : bit_cnt;
    assign pop         = cmd_valid & cmd_ready;
    assign cmd_valid   = ~fifo_empty;

    // primed stays low until load is seen low through a settled synchroniser, so a
    // load already high when reset releases never opens a frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle       <= 2'd0;
            primed       <= 1'b0;
            frame_on     <= 1'b0;
            has_byte     <= 1'b0;
            bit_cnt      <= 3'd0;
            sr           <= '0;
            cand         <= '0;
            action       <= '0;
            action_valid <= 1'b0;
            frame_err    <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            action_valid <= 1'b0;
            frame_err    <= 1'b0;

            if (settle != 2'd2)
                settle <= settle + 2'd1;
            else if (!load_s2)
                primed <= 1'b1;

            if (load_rise && primed) begin
                frame_on <= 1'b1;
                bit_cnt  <= 3'd0;
                sr       <= '0;
                has_byte <= 1'b0;
            end else if (frame_on) begin
                if (bit_en) begin
                    sr      <= new_byte[6:0];
                    bit_cnt <= bit_cnt_nxt;
                    if (byte_done) begin
                        cand     <= new_byte;
                        has_byte <= 1'b1;
                    end
                end
                if (load_fall) begin
                    frame_on <= 1'b0;
                    bit_cnt  <= 3'd0;
                    if (has_byte || byte_done) begin
                        action       <= byte_done ? new_byte : cand;
                        action_valid <= 1'b1;
                    end
                    if (bit_cnt_nxt != 3'd0)
                        frame_err <= 1'b1;
                end
            end

            if (byte_done && fifo_full && !pop)
                overflow <= 1'b1;
        end
    end

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (byte_done),
        .push_data (new_byte),
        .pop       (pop),
        .head      (cmd_byte),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_spi_raspi_cmd_rx.sv
// tb/tb_spi_raspi_cmd_rx.sv - self-checking bench for spi_raspi_cmd_rx against a transaction-level model
module tb_spi_raspi_cmd_rx;
    import raspi_spi_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset, sclk, load, sdi, cmd_ready;
    cmd_t cmd_byte, action;
    logic cmd_valid, action_valid, frame_err, overflow;

    spi_raspi_cmd_rx #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .sclk         (sclk),
        .load         (load),
        .sdi          (sdi),
        .cmd_byte     (cmd_byte),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .action       (action),
        .action_valid (action_valid),
        .frame_err    (frame_err),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   av_cnt = 0;
    int   fe_cnt = 0;
    int   occ    = 0;
    cmd_t got_q[$];
    cmd_t exp_q[$];
    cmd_t tx_q[$];
    cmd_t exp_action = 8'h00;
    logic exp_ovf    = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (cmd_valid && cmd_ready) got_q.push_back(cmd_byte);
            if (action_valid) av_cnt++;
            if (frame_err) fe_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_byte(input cmd_t b);
        if (cmd_ready) exp_q.push_back(b);
        else if (occ < DEPTH) begin
            exp_q.push_back(b);
            occ++;
        end else exp_ovf = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        sdi = b; tick(3);
        sclk = 1'b1; tick(5);
        sclk = 1'b0; tick(2);
    endtask

    task automatic send_byte(input cmd_t b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        model_byte(b);
    endtask

    task automatic send_frame(input int extra);
        int av0, fe0;
        av0 = av_cnt; fe0 = fe_cnt;
        load = 1'b1; tick(3);
        foreach (tx_q[i]) send_byte(tx_q[i]);
        for (int i = 0; i < extra; i++) send_bit(1'($urandom_range(0, 1)));
        load = 1'b0; tick(6);
        if (tx_q.size() > 0) exp_action = tx_q[tx_q.size()-1];
        chk("action", action, exp_action);
        chk("action_valid_pulses", av_cnt - av0, (tx_q.size() > 0) ? 1 : 0);
        chk("frame_err_pulses", fe_cnt - fe0, (extra % 8 != 0) ? 1 : 0);
        chk("overflow", overflow, exp_ovf);
        tx_q.delete();
    endtask

    task automatic drain();
        cmd_ready = 1'b1; tick(DEPTH + 3);
        cmd_ready = 1'b0; tick(1);
        occ = 0;
        chk("pop_count", got_q.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < got_q.size()) chk($sformatf("pop%0d", i), got_q[i], exp_q[i]);
        chk("empty_valid", cmd_valid, 0);
        chk("empty_byte", cmd_byte, 0);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        cmd_t b;
        int   av0;

        reset = 1'b1; sclk = 1'b0; load = 1'b0; sdi = 1'b0; cmd_ready = 1'b0;
        tick(3);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_byte", cmd_byte, 0);
        chk("rst_action", action, 0);
        chk("rst_action_valid", action_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overflow", overflow, 0);
        reset = 1'b0; tick(5);

        // single byte with push latency measured from the 8th sclk rise
        b = 8'hA5;
        av0 = av_cnt;
        load = 1'b1; tick(3);
        for (int i = 7; i >= 1; i--) send_bit(b[i]);
        sdi = b[0]; tick(3);
        sclk = 1'b1; tick(1);
        tick(1);
        chk("lat_edge1_valid", cmd_valid, 0);
        tick(1);
        chk("lat_edge2_valid", cmd_valid, 1);
        chk("lat_edge2_byte", cmd_byte, 8'hA5);
        tick(2); sclk = 1'b0; tick(2);
        model_byte(b);
        load = 1'b0; tick(6);
        chk("a5_action", action, 8'hA5);
        chk("a5_action_valid_pulses", av_cnt - av0, 1);
        chk("a5_frame_err", fe_cnt, 0);
        exp_action = 8'hA5;
        drain();

        // three bytes drained as they arrive
        cmd_ready = 1'b1;
        tx_q = '{8'h12, 8'h34, 8'h56};
        send_frame(0);
        drain();

        for (int r = 0; r < 3; r++) begin
            cmd_ready = 1'b1;
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) tx_q.push_back(8'($urandom));
            send_frame(0);
            drain();
        end

        // trailing partial byte, then a frame with no complete byte
        cmd_ready = 1'b0;
        tx_q = '{8'h3C};
        send_frame(5);
        send_frame(3);
        drain();

        // full FIFO with push and pop landing on the same edge
        for (int k = 0; k < DEPTH; k++) tx_q.push_back(8'($urandom));
        send_frame(0);
        b = 8'($urandom);
        load = 1'b1; tick(3);
        for (int i = 7; i >= 1; i--) send_bit(b[i]);
        sdi = b[0]; tick(3);
        sclk = 1'b1; tick(1);
        tick(1);
        cmd_ready = 1'b1; tick(1);
        cmd_ready = 1'b0;
        chk("pp_still_valid", cmd_valid, 1);
        tick(2); sclk = 1'b0; tick(2);
        exp_q.push_back(b);
        load = 1'b0; tick(6);
        chk("pp_overflow", overflow, 0);
        chk("pp_action", action, b);
        exp_action = b;
        drain();

        // overflow on the fifth byte, sticky across a drain
        tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_frame(0);
        chk("ovf_set", overflow, 1);
        drain();
        chk("ovf_sticky", overflow, 1);

        // reset mid-byte with load held high through release
        load = 1'b1; tick(3);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        reset = 1'b1; #2;
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_cmd_valid", cmd_valid, 0);
        chk("mid_rst_action", action, 0);
        tick(2);
        reset = 1'b0;
        exp_action = 8'h00; exp_ovf = 1'b0; occ = 0;
        got_q.delete(); exp_q.delete();
        av0 = av_cnt;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        load = 1'b0; tick(6);
        chk("post_rst_no_push", cmd_valid, 0);
        chk("post_rst_no_action", av_cnt - av0, 0);
        chk("post_rst_action", action, 0);
        tx_q = '{8'hFF};
        send_frame(0);
        chk("post_rst_ff_valid", cmd_valid, 1);
        chk("post_rst_ff_byte", cmd_byte, 8'hFF);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_raspi_cmd_rx.md
# spi_raspi_cmd_rx

Command receiver for the Raspberry Pi SPI link: the Pi-to-FPGA direction of the interface whose FPGA-to-Pi side shifts string readings out on `sdo`. It oversamples `sclk`/`load`/`sdi` in the `clk` domain, assembles MSB-first bytes, and buffers them in a small FIFO drained with a valid/ready handshake. It also latches the last complete byte of each frame as the `action` command. It sits beside the string-readout slave in `final_project` and shares the same `sclk`/`load` pins.

## Interface
- `FIFO_DEPTH`, 4, command FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock; sole clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `sclk`  in  1  SPI clock from Pi; asynchronous to `clk`.
- `load`  in  1  frame enable from Pi, active-high; low = idle.
- `sdi`  in  1  serial data from Pi, sampled on `sclk` rise.
- `cmd_byte`  out  8  FIFO head; 8'h00 when empty.
- `cmd_valid`  out  1  FIFO non-empty.
- `cmd_ready`  in  1  consumer accepts head when `cmd_valid` is high.
- `action`  out  8  last complete byte of the most recent frame.
- `action_valid`  out  1  one-clk pulse when `action` updates.
- `frame_err`  out  1  one-clk pulse when a frame ends mid-byte.
- `overflow`  out  1  sticky; set when a byte is dropped on full FIFO.

## Operation
- Synchronisers: `sclk`, `load`, `sdi` each pass through 2 flops (s1, s2); a third flop s3 on `sclk` and `load` gives edge detects. `sclk_rise` = s2 & ~s3; `load_rise` and `load_fall` are formed the same way. `sdi` s2 is sampled together with `sclk_rise`.
- `load_rise`: bit counter ← 0, shift register ← 0, frame-has-byte flag ← 0.
- `sclk_rise` with `load` s2 high: shift register ← {sr[6:0], sdi_s2}, and the bit counter increments mod 8.
  - On the 8th bit (counter 7→0), the assembled byte {sr[6:0], sdi_s2} is pushed to the FIFO.
  - The same byte is held as the frame's candidate action, and frame-has-byte ← 1.
- `sclk_rise` with `load` low: ignored.
- `load_fall`:
  - If frame-has-byte, `action` ← candidate and `action_valid` pulses.
  - If the bit counter ≠ 0, `frame_err` pulses and the partial bits are discarded; they are never pushed.
  - A frame with zero complete bytes leaves `action` unchanged.
- Same-cycle `sclk_rise` and `load_fall`: the bit is processed first, then frame end. A byte completed that cycle becomes the action, with no `frame_err`.
- FIFO:
  - Pop occurs when `cmd_valid` & `cmd_ready`.
  - A push to a full FIFO drops the byte and sets `overflow`, unless a pop occurs in the same cycle; then both proceed and there is no overflow.
  - Pop when empty is ignored.
  - Pointers wrap modulo `FIFO_DEPTH`; the count is log2(`FIFO_DEPTH`)+1 bits.
- `reset` mid-frame: all outputs are at reset values immediately. Bits after release count only once `load_rise` is seen; a `load` already high at release is ignored until it falls and rises again.

## Timing
- Reset values: `cmd_byte` 8'h00, `cmd_valid` 0, `action` 8'h00, `action_valid` 0, `frame_err` 0, `overflow` 0; FIFO empty; sync flops 0.
- Latency: let edge 0 be the `clk` edge where s1 first captures `sclk`=1 on the 8th bit.
  - At edge 1, s2=1.
  - At edge 2, the push occurs, and `cmd_valid` is high after edge 2.
  - `load_fall` → `action`/`action_valid` follows the same 2-edge latency.
- Input constraints:
  - `sclk` high and low each ≥4 `clk` periods.
  - `sdi` stable from 2 `clk` before to 2 `clk` after each `sclk` rise.
  - `load` high ≥2 `clk` before the first `sclk` rise.
- `cmd_byte` is registered from FIFO memory and valid in the same cycle as `cmd_valid`. A pop updates the head on the next edge.
- Throughput: the FIFO accepts 1 push and 1 pop per cycle.

## Structure
- Package `raspi_spi_pkg`: `CMD_W` = 8, `DEFAULT_FIFO_DEPTH` = 4, typedef `cmd_t` (logic [7:0]). It also holds command opcode constants shared with the consumer logic.
- Sub-module `cmd_fifo` (synchronous FIFO with parameter DEPTH, push/pop/full/empty, async reset). The top holds the synchronisers, edge detects, shifter, and frame logic.

## Test plan
- One frame, byte 8'hA5, `sclk` period 10 clk → one push, `cmd_byte`=8'hA5 with `cmd_valid` 2 clk after edge 0. On `load` fall, `action`=8'hA5 and `action_valid` pulses once; `frame_err`=0.
- Frame of 8'h12, 8'h34, 8'h56 with `cmd_ready`=1 → FIFO delivers 12, 34, 56 in order; `action`=8'h56.
- Frame of 8'h3C followed by 5 extra bits, then `load` falls → `frame_err` pulses; `action`=8'h3C; FIFO holds only 8'h3C.
- `cmd_ready`=0, 5 bytes 01..05 with `FIFO_DEPTH`=4 → FIFO holds 01..04 and `overflow`=1. Drain yields 01..04, and `overflow` stays 1 until `reset`.
- `reset` asserted after 4 bits of a byte, released with `load` still high, 4 more bits sent → no push and no `action_valid`. A new `load` rise followed by 8'hFF yields `cmd_byte`=8'hFF.
- Push and pop in the same cycle on a full FIFO → count stays `FIFO_DEPTH`, `overflow` stays 0, and order is preserved.
